// File: rtl/fpu_add_pkg.sv
// Shared types and constants for the FP32 adder back end.
// Rounding-mode encodings, FSM states and the overflow result-select helper.
package fpu_add_pkg;

  localparam int             FRAC_W     = 27;
  localparam int             EXP_W      = 8;
  localparam int             BIAS       = 127;
  localparam logic [7:0]     EXP_MAX    = 8'hFF;
  localparam logic [30:0]    MAX_FINITE = 31'h7F7FFFFF;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } rm_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Overflow saturates to infinity unless the mode rounds toward zero for this sign.
  function automatic logic ovf_to_inf(input logic [2:0] frm, input logic sign);
    logic to_inf;
    case (frm)
      RTZ:     to_inf = 1'b0;
      RDN:     to_inf = sign;
      RUP:     to_inf = ~sign;
      default: to_inf = 1'b1;
    endcase
    return to_inf;
  endfunction

endpackage

// File: rtl/fp_add_round.sv
// Combinational rounding, overflow saturation and IEEE-754 single packing
// for a normalized (or subnormal) fraction.
module fp_add_round
  import fpu_add_pkg::*;
(
  input  logic              sign,
  input  logic signed [9:0] exp,
  input  logic [25:0]       frac,
  input  logic [2:0]        frm,
  output logic [31:0]       result,
  output logic              overflow,
  output logic              underflow,
  output logic              inexact
);

  logic              guard;
  logic              sticky;
  logic              lsb;
  logic              rnd_inexact;
  logic              inc;
  logic [24:0]       sum;
  logic signed [9:0] exp_fin;
  logic [22:0]       mant;

  always_comb begin
    guard       = frac[1];
    sticky      = frac[0];
    lsb         = frac[2];
    rnd_inexact = guard | sticky;

    case (frm)
      RTZ:     inc = 1'b0;
      RDN:     inc = rnd_inexact & sign;
      RUP:     inc = rnd_inexact & ~sign;
      RMM:     inc = guard;
      default: inc = guard & (sticky | lsb);
    endcase

    sum = {1'b0, frac[25:2]} + {24'd0, inc};

    // Carry-out of the significand renormalizes by bumping the exponent;
    // a subnormal that reaches bit 23 becomes the smallest normal.
    if (sum[24]) begin
      exp_fin = exp + 10'sd1;
      mant    = 23'd0;
    end else if (sum[23]) begin
      exp_fin = frac[25] ? exp : 10'sd1;
      mant    = sum[22:0];
    end else begin
      exp_fin = 10'sd0;
      mant    = sum[22:0];
    end

    overflow = (exp_fin >= 10'sd255);

    if (overflow) begin
      result = ovf_to_inf(frm, sign) ? {sign, EXP_MAX, 23'd0} : {sign, MAX_FINITE};
    end else begin
      result = {sign, exp_fin[7:0], mant};
    end

    inexact   = rnd_inexact | overflow;
    underflow = ~overflow & (exp_fin == 10'sd0) & rnd_inexact;
  end

endmodule

// File: rtl/fp_add_normalize_pack.sv
// FP32 adder back end: iterative normalization of the raw sum, rounding and
// packing, with valid/ready handshakes on input and output.
module fp_add_normalize_pack
  import fpu_add_pkg::*;
#(
  parameter int NORM_STEP = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign_in,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic [FRAC_W-1:0] frac_in,
  input  logic [2:0]        frm_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       floating_point_out,
  output logic [2:0]        frm_out,
  output logic              flag_overflow,
  output logic              flag_underflow,
  output logic              flag_inexact
);

  localparam logic signed [9:0] STEP_LIM = 10'(NORM_STEP);

  state_t              state_reg,  state_next;
  logic                sign_reg,   sign_next;
  logic signed [9:0]   exp_reg,    exp_next;
  logic [FRAC_W-1:0]   frac_reg,   frac_next;
  logic [2:0]          frm_reg,    frm_next;
  logic [31:0]         result_reg, result_next;
  logic                ovf_reg,    ovf_next;
  logic                unf_reg,    unf_next;
  logic                inx_reg,    inx_next;

  logic [4:0]          lzc;
  logic signed [9:0]   shift_amt;
  logic [FRAC_W-1:0]   norm_frac;
  logic signed [9:0]   norm_exp;

  logic [31:0]         rnd_result;
  logic                rnd_ovf;
  logic                rnd_unf;
  logic                rnd_inx;

  // Leading zeros measured from the hidden-bit position downward.
  always_comb begin
    lzc = 5'd26;
    for (int i = 0; i < 26; i++) begin
      if (frac_reg[i]) lzc = 5'(25 - i);
    end
  end

  // Left shift never exceeds the step size nor pushes the exponent below 1.
  always_comb begin
    shift_amt = $signed({5'd0, lzc});
    if (shift_amt > STEP_LIM) shift_amt = STEP_LIM;
    if (shift_amt > exp_reg - 10'sd1) shift_amt = exp_reg - 10'sd1;
    norm_frac = frac_reg << shift_amt[4:0];
    norm_exp  = exp_reg - shift_amt;
  end

  fp_add_round u_round (
    .sign      (sign_reg),
    .exp       (exp_reg),
    .frac      (frac_reg[25:0]),
    .frm       (frm_reg),
    .result    (rnd_result),
    .overflow  (rnd_ovf),
    .underflow (rnd_unf),
    .inexact   (rnd_inx)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= IDLE;
      sign_reg   <= 1'b0;
      exp_reg    <= 10'sd0;
      frac_reg   <= '0;
      frm_reg    <= 3'd0;
      result_reg <= 32'd0;
      ovf_reg    <= 1'b0;
      unf_reg    <= 1'b0;
      inx_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sign_reg   <= sign_next;
      exp_reg    <= exp_next;
      frac_reg   <= frac_next;
      frm_reg    <= frm_next;
      result_reg <= result_next;
      ovf_reg    <= ovf_next;
      unf_reg    <= unf_next;
      inx_reg    <= inx_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    sign_next   = sign_reg;
    exp_next    = exp_reg;
    frac_next   = frac_reg;
    frm_next    = frm_reg;
    result_next = result_reg;
    ovf_next    = ovf_reg;
    unf_next    = unf_reg;
    inx_next    = inx_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          sign_next = sign_in;
          exp_next  = $signed({2'b00, exp_in});
          frac_next = frac_in;
          frm_next  = frm_in;
          if (exp_in == EXP_MAX) begin
            result_next = {sign_in, EXP_MAX, frac_in[24:2]};
            ovf_next    = 1'b0;
            unf_next    = 1'b0;
            inx_next    = 1'b0;
            state_next  = DONE;
          end else if (frac_in == '0) begin
            result_next = {(frm_in == RDN), 31'd0};
            ovf_next    = 1'b0;
            unf_next    = 1'b0;
            inx_next    = 1'b0;
            state_next  = DONE;
          end else begin
            state_next  = NORM;
          end
        end
      end

      NORM: begin
        if (frac_reg[26]) begin
          frac_next  = {1'b0, frac_reg[26:2], frac_reg[1] | frac_reg[0]};
          exp_next   = exp_reg + 10'sd1;
          state_next = ROUND;
        end else if (!frac_reg[25] && (exp_reg > 10'sd1)) begin
          frac_next = norm_frac;
          exp_next  = norm_exp;
          // Leave as soon as this shift completes normalization.
          if (norm_frac[25] || (norm_exp <= 10'sd1)) state_next = ROUND;
        end else begin
          state_next = ROUND;
        end
      end

      ROUND: begin
        result_next = rnd_result;
        ovf_next    = rnd_ovf;
        unf_next    = rnd_unf;
        inx_next    = rnd_inx;
        state_next  = DONE;
      end

      DONE: begin
        if (out_ready) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign in_ready           = (state_reg == IDLE);
  assign out_valid          = (state_reg == DONE);
  assign floating_point_out = result_reg;
  assign frm_out            = frm_reg;
  assign flag_overflow      = ovf_reg;
  assign flag_underflow     = unf_reg;
  assign flag_inexact       = inx_reg;

endmodule
